// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST controller.
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int         NUM_ELEMS = 6;
    localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEMS - 1);

    // Background patterns as a single bit; replicated to the data width at the use site.
    localparam logic BG0 = 1'b0;
    localparam logic BG1 = 1'b1;

    typedef struct packed {
        logic down;
        logic two_ops;
        logic op0_wr;
        logic op0_bg;
        logic op1_wr;
        logic op1_bg;
    } elem_t;

    function automatic elem_t elem_info(input logic [2:0] e);
        elem_t r;
        r = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b1, op0_bg: BG0, op1_wr: 1'b0, op1_bg: BG0};
        case (e)
            3'd0: r = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b1, op0_bg: BG0, op1_wr: 1'b0, op1_bg: BG0};
            3'd1: r = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_bg: BG0, op1_wr: 1'b1, op1_bg: BG1};
            3'd2: r = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_bg: BG1, op1_wr: 1'b1, op1_bg: BG0};
            3'd3: r = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_bg: BG0, op1_wr: 1'b1, op1_bg: BG1};
            3'd4: r = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_bg: BG1, op1_wr: 1'b1, op1_bg: BG0};
            3'd5: r = '{down: 1'b1, two_ops: 1'b0, op0_wr: 1'b0, op0_bg: BG0, op1_wr: 1'b0, op1_bg: BG0};
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// Delays read expectations to meet returning read data, compares, and captures the first failure.
// MBIST_ERR_LOG_EN adds a saturating mismatch counter.
module mbist_cmp_pipe
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_rd,
    input  logic [DATA_WIDTH-1:0] in_exp,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [2:0]            in_elem,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  mismatch,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data
`ifdef MBIST_ERR_LOG_EN
    ,
    output logic [15:0]           err_count
`endif
);

    logic [2:0]            rd_q, rd_d;
    logic [DATA_WIDTH-1:0] exp_q  [3];
    logic [DATA_WIDTH-1:0] exp_d  [3];
    logic [ADDR_WIDTH-1:0] addr_q [3];
    logic [ADDR_WIDTH-1:0] addr_d [3];
    logic [2:0]            elem_q [3];
    logic [2:0]            elem_d [3];

    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]            fail_elem_q, fail_elem_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
    logic [15:0]           err_q, err_d;

    assign mismatch = rd_q[2] && (rdata != exp_q[2]);

    always_comb begin
        rd_d      = {rd_q[1:0], in_rd};
        exp_d[0]  = in_exp;
        exp_d[1]  = exp_q[0];
        exp_d[2]  = exp_q[1];
        addr_d[0] = in_addr;
        addr_d[1] = addr_q[0];
        addr_d[2] = addr_q[1];
        elem_d[0] = in_elem;
        elem_d[1] = elem_q[0];
        elem_d[2] = elem_q[1];

        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_data_d = fail_data_q;
        err_d       = err_q;

        if (clr) begin
            fail_d      = 1'b0;
            fail_addr_d = '0;
            fail_elem_d = '0;
            fail_data_d = '0;
            err_d       = '0;
        end else if (mismatch) begin
            fail_d = 1'b1;
            // Only the first mismatch of a run is recorded.
            if (!fail_q) begin
                fail_addr_d = addr_q[2];
                fail_elem_d = elem_q[2];
                fail_data_d = rdata;
            end
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q        <= '0;
            for (int i = 0; i < 3; i++) begin
                exp_q[i]  <= '0;
                addr_q[i] <= '0;
                elem_q[i] <= '0;
            end
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_data_q <= '0;
            err_q       <= '0;
        end else begin
            rd_q        <= rd_d;
            exp_q       <= exp_d;
            addr_q      <= addr_d;
            elem_q      <= elem_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_data_q <= fail_data_d;
            err_q       <= err_d;
        end
    end

    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign fail_data = fail_data_q;
`ifdef MBIST_ERR_LOG_EN
    assign err_count = err_q;
`endif

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: sequences memory ops, feeds the compare pipe, reports results.
// MBIST_ERR_LOG_EN: keep running past mismatches and expose err_count.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data
`ifdef MBIST_ERR_LOG_EN
    ,
    output logic [15:0]           err_count
`endif
);

    localparam logic [ADDR_WIDTH-1:0] CAP = ADDR_WIDTH'(CAPACITY);
`ifdef MBIST_ERR_LOG_EN
    localparam bit STOP_ON_FAIL = 1'b0;
`else
    localparam bit STOP_ON_FAIL = 1'b1;
`endif

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  sub_q, sub_d;
    logic [1:0]            drain_q, drain_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Issue stage: op decoded this cycle, presented to memory one cycle later.
    logic                  a_wr_q, a_wr_d;
    logic                  a_rd_q, a_rd_d;
    logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
    logic                  a_exp_q, a_exp_d;
    logic [2:0]            a_elem_q, a_elem_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_read_q, write_read_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;

    elem_t info, next_info;
    logic  cur_wr, cur_bg, last_sub, last_addr, last_op, start_ok, mismatch, abort;

    always_comb begin
        info      = elem_info(elem_q);
        next_info = elem_info(elem_q + 3'd1);
        cur_wr    = sub_q ? info.op1_wr : info.op0_wr;
        cur_bg    = sub_q ? info.op1_bg : info.op0_bg;
        last_sub  = !info.two_ops || sub_q;
        last_addr = info.down ? (addr_q == '0) : (addr_q == CAP);
        last_op   = last_sub && last_addr && (elem_q == LAST_ELEM);
        start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
        abort     = STOP_ON_FAIL && mismatch;
    end

    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        addr_d       = addr_q;
        sub_d        = sub_q;
        drain_d      = drain_q;
        busy_d       = busy_q;
        done_d       = done_q;
        a_wr_d       = 1'b0;
        a_rd_d       = 1'b0;
        a_addr_d     = a_addr_q;
        a_exp_d      = a_exp_q;
        a_elem_d     = a_elem_q;
        wdata_d      = '0;
        write_read_d = a_wr_q;
        address_d    = a_addr_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = ST_RUN;
                    elem_d  = '0;
                    addr_d  = '0;
                    sub_d   = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_DRAIN;
                    drain_d = 2'd3;
                end else begin
                    a_wr_d   = cur_wr;
                    a_rd_d   = !cur_wr;
                    a_addr_d = addr_q;
                    a_exp_d  = cur_bg;
                    a_elem_d = elem_q;
                    wdata_d  = cur_wr ? {DATA_WIDTH{cur_bg}} : '0;
                    if (last_op) begin
                        state_d = ST_DRAIN;
                        drain_d = 2'd3;
                    end else if (!last_sub) begin
                        sub_d = 1'b1;
                    end else begin
                        sub_d = 1'b0;
                        if (last_addr) begin
                            elem_d = elem_q + 3'd1;
                            addr_d = next_info.down ? CAP : '0;
                        end else begin
                            addr_d = info.down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            elem_q       <= '0;
            addr_q       <= '0;
            sub_q        <= 1'b0;
            drain_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            a_wr_q       <= 1'b0;
            a_rd_q       <= 1'b0;
            a_addr_q     <= '0;
            a_exp_q      <= 1'b0;
            a_elem_q     <= '0;
            wdata_q      <= '0;
            write_read_q <= 1'b0;
            address_q    <= '0;
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            addr_q       <= addr_d;
            sub_q        <= sub_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            a_wr_q       <= a_wr_d;
            a_rd_q       <= a_rd_d;
            a_addr_q     <= a_addr_d;
            a_exp_q      <= a_exp_d;
            a_elem_q     <= a_elem_d;
            wdata_q      <= wdata_d;
            write_read_q <= write_read_d;
            address_q    <= address_d;
        end
    end

    mbist_cmp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .in_rd     (a_rd_q),
        .in_exp    ({DATA_WIDTH{a_exp_q}}),
        .in_addr   (a_addr_q),
        .in_elem   (a_elem_q),
        .rdata     (rdata),
        .mismatch  (mismatch),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .fail_data (fail_data)
`ifdef MBIST_ERR_LOG_EN
        ,
        .err_count (err_count)
`endif
    );

    assign write_read = write_read_q;
    assign address    = address_q;
    assign wdata      = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
